pb_board_responder: RTL and testbench

//  Target (board) end of the parallel peripheral bus driven by the command FPGA: decodes BOARD_X

---
 rtl/pb_bus_pkg.sv | 22 ++
 rtl/pb_sync2.sv | 26 ++
 rtl/pb_board_responder.sv | 176 +++++++++++++++++
 tb/tb_pb_board_responder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_bus_pkg.sv
// Shared definitions for the board end of the parallel peripheral bus: FSM states,
// register map constants and the default ID byte.
package pb_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        TURN,
        WR,
        RECOVER
    } pb_state_t;

    localparam int         PB_NUM_OUT_REGS    = 4;
    localparam int         PB_ADDR_IN_BASE    = 4;
    localparam logic [7:0] PB_DEFAULT_ID_BYTE = 8'hA5;

    // Addresses below the in_regs base map onto the writable output registers.
    function automatic logic is_out_addr(input logic [2:0] addr);
        return int'(addr) < PB_ADDR_IN_BASE;
    endfunction

endpackage

// File: rtl/pb_sync2.sv
// Parameterised-width two-flop synchronizer with a configurable reset value.
module pb_sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: both stages use non-blocking assignments so meta and q form two distinct
    // flops; a blocking assignment here would collapse the chain into a single stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pb_board_responder.sv
// Board (target) end of the parallel peripheral bus: synchronizes the bus pins, decodes
// read/write strobes and serves the register map. Optional macro: PB_RESP_ERR_CNT_EN.
module pb_board_responder
    import pb_bus_pkg::*;
#(
    parameter logic [3:0] BOARD_ID       = 4'h0,
    parameter logic [7:0] ID_BYTE        = PB_DEFAULT_ID_BYTE,
    parameter int         STROBE_TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  board_sel,
    input  logic [2:0]  addr_in,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        test_addr,
    input  logic        lamp_reset,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [31:0] out_regs,
    input  logic [31:0] in_regs,
    output logic [7:0]  err_count
);

    localparam int               TMO_W    = $clog2(STROBE_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(STROBE_TIMEOUT - 1);

    logic       rd_s, wr_s, test_s, lamp_s;
    logic [3:0] sel_s;
    logic [2:0] addr_s;
    logic [7:0] data_s;
    logic       selected;

    pb_sync2 #(.WIDTH(2), .RST_VAL(2'b11)) u_sync_strobe (
        .clock (clock),
        .reset (reset),
        .d     ({rd_n, wr_n}),
        .q     ({rd_s, wr_s})
    );

    pb_sync2 #(.WIDTH(9), .RST_VAL(9'h000)) u_sync_ctrl (
        .clock (clock),
        .reset (reset),
        .d     ({board_sel, addr_in, test_addr, lamp_reset}),
        .q     ({sel_s, addr_s, test_s, lamp_s})
    );

    pb_sync2 #(.WIDTH(8), .RST_VAL(8'h00)) u_sync_data (
        .clock (clock),
        .reset (reset),
        .d     (data_in),
        .q     (data_s)
    );

    assign selected = (sel_s == BOARD_ID);

    pb_state_t                             state;
    logic [2:0]                            addr_q;
    logic                                  test_q;
    logic [7:0]                            wr_data;
    logic [TMO_W-1:0]                      tmo_cnt;
    logic [PB_NUM_OUT_REGS-1:0][7:0]       regs_q;
    logic [3:0][7:0]                       in_bytes;
    logic [7:0]                            read_byte;
    logic                                  err_pulse;

    assign in_bytes = in_regs;
    assign out_regs = regs_q;

    always_comb begin
        read_byte = ID_BYTE;
        if (!test_q) begin
            if (is_out_addr(addr_q)) read_byte = regs_q[addr_q[1:0]];
            else                     read_byte = in_bytes[addr_q[1:0]];
        end
    end

    // NOTE: the output registers are only four bytes, so they sit in the synchronous reset
    // with everything else rather than being left uninitialised like a RAM would be.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            test_q    <= 1'b0;
            wr_data   <= '0;
            tmo_cnt   <= '0;
            regs_q    <= '0;
            err_pulse <= 1'b0;
            data_out  <= '0;
            data_oe   <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    data_oe <= 1'b0;
                    tmo_cnt <= '0;
                    if (!rd_s && !wr_s) begin
                        err_pulse <= 1'b1;
                        state     <= RECOVER;
                    end else if (!rd_s && selected) begin
                        addr_q <= addr_s;
                        test_q <= test_s;
                        state  <= RD;
                    end else if (!wr_s && selected) begin
                        addr_q  <= addr_s;
                        wr_data <= data_s;
                        state   <= WR;
                    end
                end
                RD: begin
                    if (!wr_s) begin
                        data_oe   <= 1'b0;
                        err_pulse <= 1'b1;
                        state     <= RECOVER;
                    end else if (rd_s) begin
                        data_oe <= 1'b0;
                        state   <= TURN;
                    end else if (tmo_cnt == TMO_LAST) begin
                        data_oe   <= 1'b0;
                        err_pulse <= 1'b1;
                        state     <= RECOVER;
                    end else begin
                        tmo_cnt  <= tmo_cnt + TMO_W'(1);
                        data_oe  <= 1'b1;
                        data_out <= read_byte;
                    end
                end
                TURN: begin
                    data_oe <= 1'b0;
                    state   <= IDLE;
                end
                WR: begin
                    // wr_data holds the last sample seen while wr_s was still low.
                    if (!rd_s) begin
                        err_pulse <= 1'b1;
                        state     <= RECOVER;
                    end else if (wr_s) begin
                        if (is_out_addr(addr_q)) regs_q[addr_q[1:0]] <= wr_data;
                        else                     err_pulse <= 1'b1;
                        state <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_pulse <= 1'b1;
                        state     <= RECOVER;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        wr_data <= data_s;
                    end
                end
                RECOVER: begin
                    data_oe <= 1'b0;
                    if (rd_s && wr_s) state <= IDLE;
                end
                default: begin
                    data_oe <= 1'b0;
                    state   <= IDLE;
                end
            endcase

            // Lamp reset is placed last so it overrides a same-cycle write commit.
            if (lamp_s) regs_q <= '0;
        end
    end

`ifdef PB_RESP_ERR_CNT_EN
    always_ff @(posedge clock) begin
        if (reset)                                 err_count <= 8'h00;
        else if (err_pulse && err_count != 8'hFF)  err_count <= err_count + 8'h01;
    end
`else
    logic unused_err_pulse;
    assign unused_err_pulse = err_pulse;
    assign err_count        = 8'h00;
`endif

endmodule

// File: tb/tb_pb_board_responder.sv
// Self-checking bench for pb_board_responder: directed bus scenarios plus randomized
// read/write transactions against a transaction-level register-map model.
module tb_pb_board_responder;

    localparam logic [3:0] BOARD_ID       = 4'h3;
    localparam logic [7:0] ID_BYTE        = 8'hA5;
    localparam int         STROBE_TIMEOUT = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  board_sel;
    logic [2:0]  addr_in;
    logic        rd_n, wr_n, test_addr, lamp_reset;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [31:0] out_regs;
    logic [31:0] in_regs;
    logic [7:0]  err_count;

    pb_board_responder #(
        .BOARD_ID       (BOARD_ID),
        .ID_BYTE        (ID_BYTE),
        .STROBE_TIMEOUT (STROBE_TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .board_sel  (board_sel),
        .addr_in    (addr_in),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .test_addr  (test_addr),
        .lamp_reset (lamp_reset),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .out_regs   (out_regs),
        .in_regs    (in_regs),
        .err_count  (err_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: register contents and number of protocol errors.
    logic [7:0] exp_regs [4];
    int         exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [31:0] model_regs();
        return {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
    endfunction

    function automatic logic [7:0] model_err();
`ifdef PB_RESP_ERR_CNT_EN
        return 8'(exp_err);
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [7:0] model_read(input logic [2:0] a, input logic t);
        logic [1:0] idx;
        idx = a[1:0];
        if (t)           return ID_BYTE;
        else if (a < 4)  return exp_regs[idx];
        else             return in_regs[8*idx +: 8];
    endfunction

    task automatic bump_err();
        if (exp_err < 255) exp_err++;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) exp_regs[i] = 8'h00;
    endtask

    function automatic logic [3:0] other_board();
        return BOARD_ID ^ 4'($urandom_range(1, 15));
    endfunction

    task automatic bus_write(input logic [3:0] sel, input logic [2:0] a,
                             input logic [7:0] d, input int hold);
        logic oe_seen;
        oe_seen   = 1'b0;
        board_sel = sel;
        addr_in   = a;
        data_in   = d;
        wr_n      = 1'b0;
        repeat (hold) begin
            cyc(1);
            oe_seen |= data_oe;
        end
        wr_n = 1'b1;
        cyc(2);
        oe_seen |= data_oe;
        check("wr_before_commit", out_regs, model_regs());
        if (sel == BOARD_ID) begin
            if (a < 4) exp_regs[a[1:0]] = d;
            else       bump_err();
        end
        cyc(1);
        check("wr_commit", out_regs, model_regs());
        repeat (3) begin
            cyc(1);
            oe_seen |= data_oe;
        end
        check("wr_no_oe", 32'(oe_seen), 32'd0);
        check("wr_err", 32'(err_count), 32'(model_err()));
        data_in = 8'($urandom);
    endtask

    task automatic bus_read(input logic [3:0] sel, input logic [2:0] a,
                            input logic t, input int hold);
        int   n;
        logic oe_seen;
        board_sel = sel;
        addr_in   = a;
        test_addr = t;
        rd_n      = 1'b0;
        if (sel == BOARD_ID) begin
            n = 0;
            do begin
                cyc(1);
                n++;
            end while (!data_oe && n < 12);
            check("rd_latency", 32'(n), 32'd4);
            check("rd_data", 32'(data_out), 32'(model_read(a, t)));
            if (!t && a >= 4) begin
                in_regs = $urandom;
                cyc(2);
                check("rd_resample", 32'(data_out), 32'(model_read(a, t)));
            end
            cyc(hold);
            rd_n = 1'b1;
            n = 0;
            do begin
                cyc(1);
                n++;
            end while (data_oe && n < 12);
            check("rd_release", 32'(n), 32'd3);
            cyc(1);
            check("rd_turnaround", 32'(data_oe), 32'd0);
        end else begin
            oe_seen = 1'b0;
            repeat (hold + 4) begin
                cyc(1);
                oe_seen |= data_oe;
            end
            rd_n = 1'b1;
            cyc(3);
            oe_seen |= data_oe;
            check("rd_unselected_oe", 32'(oe_seen), 32'd0);
        end
        test_addr = 1'b0;
        cyc(2);
        check("rd_err", 32'(err_count), 32'(model_err()));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        board_sel  = 4'h0;
        addr_in    = 3'd0;
        rd_n       = 1'b1;
        wr_n       = 1'b1;
        test_addr  = 1'b0;
        lamp_reset = 1'b0;
        data_in    = 8'h00;
        in_regs    = 32'h0;
        exp_err    = 0;
        clear_model();

        cyc(3);
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_data_oe", 32'(data_oe), 32'd0);
        check("reset_out_regs", out_regs, 32'd0);
        check("reset_err", 32'(err_count), 32'd0);
        reset = 1'b0;
        cyc(3);

        // Directed register-map scenarios.
        bus_write(BOARD_ID, 3'd2, 8'h3C, 4);
        in_regs = 32'h115A_2233;
        bus_read(BOARD_ID, 3'd6, 1'b0, 3);
        bus_read(BOARD_ID, 3'd1, 1'b1, 2);
        bus_read(BOARD_ID, 3'd2, 1'b0, 2);
        bus_write(other_board(), 3'd1, 8'h77, 5);
        bus_read(other_board(), 3'd2, 1'b0, 3);
        bus_write(BOARD_ID, 3'd5, 8'h99, 4);

        // Both strobes together.
        board_sel = BOARD_ID;
        addr_in   = 3'd0;
        data_in   = 8'hE1;
        rd_n      = 1'b0;
        wr_n      = 1'b0;
        cyc(6);
        check("both_low_oe", 32'(data_oe), 32'd0);
        rd_n = 1'b1;
        wr_n = 1'b1;
        bump_err();
        cyc(5);
        check("both_low_regs", out_regs, model_regs());
        check("both_low_err", 32'(err_count), 32'(model_err()));

        // Write strobe held past the timeout: aborted, and no commit on release.
        board_sel = BOARD_ID;
        addr_in   = 3'd0;
        data_in   = 8'hC7;
        wr_n      = 1'b0;
        cyc(STROBE_TIMEOUT + 10);
        check("wr_timeout_oe", 32'(data_oe), 32'd0);
        wr_n = 1'b1;
        bump_err();
        cyc(6);
        check("wr_timeout_regs", out_regs, model_regs());
        check("wr_timeout_err", 32'(err_count), 32'(model_err()));

        // Read strobe held past the timeout: bus released while still low.
        addr_in = 3'd2;
        rd_n    = 1'b0;
        cyc(STROBE_TIMEOUT + 10);
        check("rd_timeout_oe", 32'(data_oe), 32'd0);
        rd_n = 1'b1;
        bump_err();
        cyc(6);
        check("rd_timeout_err", 32'(err_count), 32'(model_err()));

        // Read strobe arriving during a write discards the pending write.
        addr_in = 3'd1;
        data_in = 8'h4D;
        wr_n    = 1'b0;
        cyc(6);
        rd_n = 1'b0;
        cyc(5);
        rd_n = 1'b1;
        wr_n = 1'b1;
        bump_err();
        cyc(6);
        check("collide_regs", out_regs, model_regs());
        check("collide_err", 32'(err_count), 32'(model_err()));
        check("collide_oe", 32'(data_oe), 32'd0);

        // Fill all output registers, then clear them with a lamp reset pulse.
        for (int i = 0; i < 4; i++)
            bus_write(BOARD_ID, 3'(i), 8'($urandom_range(1, 255)), 3);
        lamp_reset = 1'b1;
        cyc(1);
        lamp_reset = 1'b0;
        cyc(4);
        clear_model();
        check("lamp_clear", out_regs, model_regs());
        check("lamp_err_kept", 32'(err_count), 32'(model_err()));

        // Randomized transactions.
        for (int k = 0; k < 60; k++) begin
            logic [3:0] sel;
            sel     = ($urandom_range(0, 3) == 0) ? other_board() : BOARD_ID;
            in_regs = $urandom;
            if ($urandom_range(0, 9) < 6)
                bus_write(sel, 3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(3, 8));
            else
                bus_read(sel, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                         $urandom_range(1, 6));
        end

        // Synchronous reset in the middle of a read.
        board_sel = BOARD_ID;
        addr_in   = 3'd0;
        rd_n      = 1'b0;
        begin
            int n;
            n = 0;
            do begin
                cyc(1);
                n++;
            end while (!data_oe && n < 12);
            check("mid_rd_oe_up", 32'(data_oe), 32'd1);
        end
        reset = 1'b1;
        cyc(1);
        check("mid_rd_reset_oe", 32'(data_oe), 32'd0);
        check("mid_rd_reset_regs", out_regs, 32'd0);
        check("mid_rd_reset_err", 32'(err_count), 32'd0);
        rd_n = 1'b1;
        cyc(2);
        reset   = 1'b0;
        exp_err = 0;
        clear_model();
        cyc(3);
        bus_write(BOARD_ID, 3'd3, 8'h81, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
